// File: rtl/irq_encoder8_pkg.sv
// Shared constants, FSM state type and mask helper for the 8-line IRQ encoder.
package irq_encoder8_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] code2mask(input logic [CODE_W-1:0] code);
    logic [N_REQ-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/irq_encoder8_if.sv
// Grant channel: valid/ready handshake carrying the granted request index.
interface irq_encoder8_if;
  import irq_encoder8_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;

  modport master (output out_valid, output out_code, input out_ready);
  modport slave  (input out_valid, input out_code, output out_ready);

endinterface

// File: rtl/irq_encoder8_prio_enc8.sv
// Combinational highest-index priority encoder, 8 lines to 3-bit code.
// Zero latency; no handshake.
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] code,
  output logic       any
);

  // Ascending scan: the last set bit seen, i.e. the highest index, wins.
  always_comb begin
    code = '0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) code = 3'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/irq_encoder8.sv
// Sticky IRQ capture with highest-index grant over a valid/ready channel.
// Request to out_valid: 2 edges; grant held while out_ready=0, one idle cycle per grant.
module irq_encoder8 #(
  parameter int N_REQ  = irq_encoder8_pkg::N_REQ,
  parameter int CODE_W = irq_encoder8_pkg::CODE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   I_n,
  input  logic               EI_n,
  irq_encoder8_if.master     bus,
  output logic               GS_n,
  output logic               EO_n,
  output logic [N_REQ-1:0]   pending
);
  import irq_encoder8_pkg::*;

  state_t            state_q, state_next;
  logic [CODE_W-1:0] code_q, code_next;
  logic [CODE_W-1:0] enc_code;
  logic              enc_any;
  logic [N_REQ-1:0]  clr, cap, pending_next;

  prio_enc8 u_prio_enc8 (
    .req  (pending),
    .code (enc_code),
    .any  (enc_any)
  );

  always_comb begin
    state_next = state_q;
    code_next  = code_q;
    clr        = '0;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          code_next  = enc_code;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.out_ready) begin
          clr        = code2mask(code_q);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // New requests are OR'd in after the clear, so a same-cycle set wins.
  assign cap          = EI_n ? '0 : ~I_n;
  assign pending_next = (pending & ~clr) | cap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
    end else begin
      state_q <= state_next;
      code_q  <= code_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      GS_n    <= 1'b1;
      EO_n    <= 1'b1;
    end else begin
      pending <= pending_next;
      GS_n    <= ~|pending_next;
      EO_n    <= EI_n | (|pending_next);
    end
  end

  assign bus.out_valid = (state_q == PRESENT);
  assign bus.out_code  = code_q;

endmodule

// File: doc/irq_encoder8.md
IRQ_ENCODER8 -- requirements
Module: irq_encoder8

Interface
REQ-001 SHALL have parameter N_REQ, default 8, meaning the number of request lines; only 8 is supported.
REQ-002 SHALL have parameter CODE_W, default 3, meaning the output code width, equal to log2(N_REQ).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port I_n, input, 8 bits: active-low request lines; bit 7 has the highest priority.
REQ-006 SHALL have port EI_n, input, 1 bit: active-low capture enable.
REQ-007 SHALL have port out_ready, input, 1 bit: the consumer accepts out_code.
REQ-008 SHALL have port out_valid, output, 1 bit: out_code holds a granted request.
REQ-009 SHALL have port out_code, output, 3 bits: binary index of the granted request (active-high).
REQ-010 SHALL have port GS_n, output, 1 bit: registered, low when any request is pending.
REQ-011 SHALL have port EO_n, output, 1 bit: registered, low when EI_n was low and nothing was pending.
REQ-012 SHALL have port pending, output, 8 bits: sticky pending-request register, active-high.

Function
REQ-013 SHALL, each cycle EI_n=0, capture requests: pending <= (pending & ~clr) | ~I_n.
REQ-014 SHALL, each cycle EI_n=1, capture no new requests; pending changes only by clears.
REQ-015 SHALL implement a two-state FSM, IDLE and PRESENT, with out_valid=1 exactly in PRESENT.
REQ-016 SHALL, in IDLE with pending!=0, load out_code with the highest set pending index and move to PRESENT.
REQ-017 SHALL, in IDLE with pending==0, remain in IDLE.
REQ-018 SHALL give this latency: I_n[k] low at edge N sets pending[k] after edge N; out_valid rises after edge N+1.
REQ-019 SHALL hold out_code and out_valid stable in PRESENT while out_ready=0.
REQ-020 SHALL, in PRESENT with out_ready=1, clear pending[out_code] (clr) and return to IDLE.
REQ-021 SHALL complete a handshake with exactly one cycle of out_valid=0 before the next grant, giving at most one grant per 2 cycles.
REQ-022 SHALL let set win over clear: a request on the granted bit in the handshake cycle leaves that bit pending.
REQ-023 SHALL NOT preempt the current grant when a higher-priority request arrives in PRESENT.
REQ-024 SHALL let a grant in PRESENT complete normally when EI_n goes high.
REQ-025 SHALL compute GS_n <= ~|pending_next and EO_n <= EI_n | |pending_next, where pending_next is the pending register's next value.
REQ-026 SHALL keep out_code at its last value in IDLE; the value is don't-care while out_valid=0.

Reset
REQ-027 SHALL, with rst_n=0 at a rising edge, set pending=0, state=IDLE, out_valid=0, out_code=0, GS_n=1 and EO_n=1.
REQ-028 SHALL, when reset occurs in PRESENT, drop the grant and lose all pending requests.
REQ-029 SHALL ignore I_n and EI_n during reset; capture resumes on the first edge with rst_n=1.

Structure
REQ-030 SHALL place the N_REQ and CODE_W constants and the state_t enum (IDLE, PRESENT) in the shared package irq_encoder8_pkg.
REQ-031 SHALL implement highest-index selection in one combinational sub-module, prio_enc8 (8-bit in; 3-bit code plus any-bit flag out).

Verification
REQ-032 SHALL cover a single request: EI_n=0, I_n=8'b1111_1011 for one cycle, out_ready=1 -> out_valid high 2 cycles later with out_code=2, then pending=0, GS_n=1, EO_n=0.
REQ-033 SHALL cover priority order: I_n=8'b0101_1110 for one cycle, out_ready=1 -> grants in order 7, 5, 0, each followed by one idle cycle.
REQ-034 SHALL cover backpressure: pending=8'h08, out_ready=0 for 5 cycles -> out_code=3 stable with out_valid=1; I_n[6] low meanwhile does not preempt; grants are 3 then 6.
REQ-035 SHALL cover set-over-clear: I_n[4] low in the cycle granted code 4 is accepted -> pending[4] stays 1 and code 4 is granted again.
REQ-036 SHALL cover enable gating: EI_n=1, I_n=8'h00 -> pending stays 0, out_valid=0, GS_n=1, EO_n=1.
REQ-037 SHALL cover reset mid-grant: rst_n=0 for one edge in PRESENT with pending=8'hFF -> next cycle out_valid=0, pending=0, GS_n=1.
